mux_sel_sequencer: RTL and testbench



---
 rtl/mux_pkg.sv | 20 ++
 rtl/mux_sel_sequencer_sel_counter.sv | 35 +++
 rtl/mux_sel_sequencer.sv | 95 +++++++++
 tb/tb_mux_sel_sequencer.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared types and index helpers for the bit-mux select sequencer.
package mux_pkg;

  localparam int unsigned SEL_W  = 3;
  localparam int unsigned DATA_W = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  function automatic int unsigned start_idx(input bit msb_first, input int unsigned data_w);
    return msb_first ? data_w - 1 : 0;
  endfunction

  function automatic int unsigned end_idx(input bit msb_first, input int unsigned data_w);
    return msb_first ? 0 : data_w - 1;
  endfunction

endpackage

// File: rtl/mux_sel_sequencer_sel_counter.sv
// Loadable up/down select counter that saturates at its terminal value.
module sel_counter #(
  parameter int unsigned W    = 3,
  parameter bit          DOWN = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] rst_val,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  input  logic [W-1:0] end_val,
  output logic [W-1:0] cnt_q,
  output logic [W-1:0] cnt_d,
  output logic         at_end
);

  assign at_end = (cnt_q == end_val);

  // Stepping stops at the terminal value so a word never wraps.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && !at_end) begin
      cnt_d = DOWN ? cnt_q - W'(1) : cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= rst_val;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/mux_sel_sequencer.sv
// Loads a parallel word and walks the mux select across it, one beat per consumed bit.
module mux_sel_sequencer
  import mux_pkg::*;
#(
  parameter int unsigned DATA_W    = mux_pkg::DATA_W,
  parameter int unsigned SEL_W     = mux_pkg::SEL_W,
  parameter bit          MSB_FIRST = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] data_out,
  output logic [SEL_W-1:0]  sel_out,
  output logic              bit_valid,
  output logic              bit_last,
  input  logic              out_ready,
  output logic              busy
);

  localparam logic [SEL_W-1:0] START_IDX = SEL_W'(start_idx(MSB_FIRST, DATA_W));
  localparam logic [SEL_W-1:0] END_IDX   = SEL_W'(end_idx(MSB_FIRST, DATA_W));

  state_e            state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              last_q, last_d;
  logic              cnt_load, cnt_en, cnt_at_end;
  logic [SEL_W-1:0]  cnt_q, cnt_d;
  logic              accept, beat_done;

  assign in_ready  = (state_q == IDLE) || ((state_q == RUN) && last_q && out_ready);
  assign accept    = in_valid && in_ready;
  assign beat_done = (state_q == RUN) && valid_q && out_ready;

  // A consumed final beat with a waiting word reloads directly, keeping the stream gapless.
  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    valid_d  = valid_q;
    cnt_load = 1'b0;
    cnt_en   = 1'b0;
    if (accept) begin
      state_d  = RUN;
      data_d   = in_data;
      valid_d  = 1'b1;
      cnt_load = 1'b1;
    end else if (beat_done && cnt_at_end) begin
      state_d = IDLE;
      valid_d = 1'b0;
    end else if (beat_done) begin
      cnt_en = 1'b1;
    end
  end

  assign last_d = (state_d == RUN) && (cnt_d == END_IDX);

  sel_counter #(
    .W    (SEL_W),
    .DOWN (MSB_FIRST)
  ) u_sel_counter (
    .clk      (clk),
    .rst      (rst),
    .rst_val  (START_IDX),
    .load     (cnt_load),
    .load_val (START_IDX),
    .en       (cnt_en),
    .end_val  (END_IDX),
    .cnt_q    (cnt_q),
    .cnt_d    (cnt_d),
    .at_end   (cnt_at_end)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  assign data_out  = data_q;
  assign sel_out   = cnt_q;
  assign bit_valid = valid_q;
  assign bit_last  = last_q;
  assign busy      = (state_q == RUN);

endmodule

// File: tb/tb_mux_sel_sequencer.sv
// Random and directed stimulus on LSB-first and MSB-first builds against a beat-index model.
module tb_mux_sel_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       out_ready;

  logic       in_ready0, bit_valid0, bit_last0, busy0;
  logic [7:0] data_out0;
  logic [2:0] sel_out0;
  logic       in_ready1, bit_valid1, bit_last1, busy1;
  logic [7:0] data_out1;
  logic [2:0] sel_out1;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // Reference: per build, a loaded flag, the held word and the beat number within the word.
  bit         m_known;
  bit         m_loaded [2];
  logic [7:0] m_word   [2];
  int         m_k      [2];
  bit         m_acc    [2];

  always #5 clk = ~clk;

  mux_sel_sequencer #(.DATA_W(8), .SEL_W(3), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready0),
    .data_out(data_out0), .sel_out(sel_out0), .bit_valid(bit_valid0), .bit_last(bit_last0),
    .out_ready(out_ready), .busy(busy0)
  );

  mux_sel_sequencer #(.DATA_W(8), .SEL_W(3), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready1),
    .data_out(data_out1), .sel_out(sel_out1), .bit_valid(bit_valid1), .bit_last(bit_last1),
    .out_ready(out_ready), .busy(busy1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_inst(input int m);
    logic       rdy, vld, lst, bsy, mux_bit;
    logic [7:0] dat;
    logic [2:0] sel;
    int         pos;
    if (m == 0) begin
      rdy = in_ready0; vld = bit_valid0; lst = bit_last0; bsy = busy0; dat = data_out0; sel = sel_out0;
    end else begin
      rdy = in_ready1; vld = bit_valid1; lst = bit_last1; bsy = busy1; dat = data_out1; sel = sel_out1;
    end
    pos = (m == 1) ? 7 - m_k[m] : m_k[m];
    chk($sformatf("m%0d in_ready", m), 32'(rdy), 32'(!m_loaded[m] || (m_k[m] == 7 && out_ready)));
    chk($sformatf("m%0d bit_valid", m), 32'(vld), 32'(m_loaded[m]));
    chk($sformatf("m%0d busy", m), 32'(bsy), 32'(m_loaded[m]));
    chk($sformatf("m%0d bit_last", m), 32'(lst), 32'(m_loaded[m] && m_k[m] == 7));
    chk($sformatf("m%0d sel_out", m), 32'(sel), 32'(pos));
    chk($sformatf("m%0d data_out", m), 32'(dat), 32'(m_word[m]));
    if (m_loaded[m]) begin
      mux_bit = dat[sel];
      chk($sformatf("m%0d mux_bit", m), 32'(mux_bit), 32'(m_word[m][pos]));
    end
  endtask

  task automatic model_step(input int m);
    bit rdy;
    rdy = !m_loaded[m] || (m_k[m] == 7 && out_ready);
    m_acc[m] = 1'b0;
    if (rst) begin
      m_loaded[m] = 1'b0; m_word[m] = 8'h00; m_k[m] = 0;
    end else if (in_valid && rdy) begin
      m_loaded[m] = 1'b1; m_word[m] = in_data; m_k[m] = 0; m_acc[m] = 1'b1;
    end else if (m_loaded[m] && out_ready) begin
      if (m_k[m] == 7) m_loaded[m] = 1'b0;
      else             m_k[m] = m_k[m] + 1;
    end
  endtask

  // Drive at the falling edge, check 1ns later, then advance the model past the next rising edge.
  task automatic cycle(input logic r, input logic v, input logic [7:0] d, input logic o);
    rst = r; in_valid = v; in_data = d; out_ready = o;
    #1;
    if (m_known) begin
      check_inst(0);
      check_inst(1);
    end
    model_step(0);
    model_step(1);
    if (r) m_known = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int beats, stall, idx;
    bit sent_ff;
    m_known = 1'b0;
    for (int m = 0; m < 2; m++) begin
      m_loaded[m] = 1'b0; m_word[m] = 8'h00; m_k[m] = 0; m_acc[m] = 1'b0;
    end
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b1;
    @(negedge clk);

    cycle(1'b1, 1'b0, 8'h00, 1'b1);
    cycle(1'b1, 1'b0, 8'h00, 1'b1);
    repeat (2) cycle(1'b0, 1'b0, 8'h00, 1'b1);

    // Single word, no stall; the MSB build walks the same word in the opposite order.
    cycle(1'b0, 1'b1, 8'hA5, 1'b1);
    repeat (10) cycle(1'b0, 1'b0, 8'h00, 1'b1);
    cycle(1'b0, 1'b1, 8'h81, 1'b1);
    repeat (10) cycle(1'b0, 1'b0, 8'h00, 1'b1);

    // Backpressure at select 2 on the LSB build.
    cycle(1'b0, 1'b1, 8'h3C, 1'b1);
    beats = 0; stall = 0;
    for (int i = 0; i < 30; i++) begin
      logic o;
      o = !(m_loaded[0] && m_k[0] == 2 && stall < 3);
      if (!o) stall++;
      if (bit_valid0 && o) beats++;
      cycle(1'b0, 1'b0, 8'h00, o);
    end
    chk("stall_beats", 32'(beats), 32'd8);
    chk("stall_cycles", 32'(stall), 32'd3);

    // Back-to-back words with in_valid held high.
    sent_ff = 1'b0; beats = 0;
    for (int i = 0; i < 20; i++) begin
      if (bit_valid0) beats++;
      cycle(1'b0, (i < 10) || !sent_ff, sent_ff ? 8'h00 : 8'hFF, 1'b1);
      if (m_acc[0]) sent_ff = 1'b1;
    end
    chk("b2b_beats", 32'(beats), 32'd16);

    // Reset in the middle of a word.
    cycle(1'b0, 1'b1, 8'h5A, 1'b1);
    idx = 0;
    while (!(m_loaded[0] && m_k[0] == 4) && idx < 20) begin
      cycle(1'b0, 1'b0, 8'h00, 1'b1);
      idx++;
    end
    chk("rst_mid_reach", 32'(idx < 20), 32'd1);
    cycle(1'b1, 1'b0, 8'h00, 1'b1);
    repeat (4) cycle(1'b0, 1'b0, 8'h00, 1'b1);

    // Random traffic with occasional reset.
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 1) == 1), 8'($urandom),
            ($urandom_range(0, 3) != 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
